spi_slave_core: RTL and testbench

//   Parametrised SPI slave datapath: any CPOL/CPHA mode, configurable word width and bit order,

---
 rtl/spi_slave_core.sv | 113 +++++++++++
 tb/tb_spi_slave_core.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/spi_slave_core.sv
// spi_slave_core: oversampled SPI slave with any CPOL/CPHA, configurable width/bit order and TX holding register
module spi_slave_core #(
  parameter int DATA_WIDTH  = 8,
  parameter int CPOL        = 0,
  parameter int CPHA        = 0,
  parameter int MSB_FIRST   = 1,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  Clk,
  input  logic                  aRst_n,
  input  logic                  SCK,
  input  logic                  CS,
  input  logic                  MOSI,
  output logic                  MISO,
  output logic                  MISO_OE,
  input  logic [DATA_WIDTH-1:0] TXData,
  input  logic                  TXValid,
  output logic                  TXReady,
  output logic [DATA_WIDTH-1:0] RXData,
  output logic                  RXAck,
  output logic                  TXUnderrun,
  output logic                  Abort
);
  localparam int CW = $clog2(DATA_WIDTH);
  localparam logic POL = CPOL != 0;
  typedef enum logic [1:0] {IDLE, LOAD, SHIFT} state_t;
  state_t state, state_nx;
  logic [SYNC_STAGES-1:0] sck_s, cs_s, mosi_s;
  logic sck_q, cs_q, samp_p, shft_p, mosi_p, rise_p, fresh, hold_full;
  logic [DATA_WIDTH-1:0] hold, sh, rx, rx_nx;
  logic [CW-1:0] cnt;
  logic sck_c, cs_c, act, lead, trail, fall, rise, samp, shft, wrap, load, accept;
  always_ff @(posedge Clk or negedge aRst_n) begin
    if (!aRst_n) begin
      sck_s  <= {SYNC_STAGES{POL}};
      cs_s   <= '1;
      mosi_s <= '0;
      sck_q  <= POL;
      cs_q   <= 1'b1;
      samp_p <= 1'b0;
      shft_p <= 1'b0;
      mosi_p <= 1'b0;
      rise_p <= 1'b0;
    end else begin
      sck_s  <= {sck_s[SYNC_STAGES-2:0], SCK};
      cs_s   <= {cs_s[SYNC_STAGES-2:0], CS};
      mosi_s <= {mosi_s[SYNC_STAGES-2:0], MOSI};
      sck_q  <= sck_c;
      cs_q   <= cs_c;
      samp_p <= CPHA != 0 ? trail : lead;
      shft_p <= CPHA != 0 ? lead : trail;
      mosi_p <= mosi_s[SYNC_STAGES-1];
      rise_p <= rise;
    end
  end
  // SCK edges count only once CS has been low for two synced samples, so an edge coinciding with the CS fall is dropped
  always_comb begin
    sck_c    = sck_s[SYNC_STAGES-1];
    cs_c     = cs_s[SYNC_STAGES-1];
    act      = !cs_q && !cs_c;
    lead     = act && sck_q == POL && sck_c != POL;
    trail    = act && sck_q != POL && sck_c == POL;
    fall     = cs_q && !cs_c;
    rise     = !cs_q && cs_c;
    samp     = state == SHIFT && samp_p;
    shft     = state == SHIFT && shft_p;
    wrap     = samp && cnt == CW'(DATA_WIDTH - 1);
    load     = (state == IDLE && fall && !rise_p) || (shft && cnt == '0 && !fresh);
    accept   = TXValid && !hold_full;
    rx_nx    = MSB_FIRST != 0 ? {rx[DATA_WIDTH-2:0], mosi_p} : {mosi_p, rx[DATA_WIDTH-1:1]};
    state_nx = rise_p ? IDLE : state == IDLE && fall ? LOAD : state == LOAD ? SHIFT : state;
  end
  always_ff @(posedge Clk or negedge aRst_n) begin
    if (!aRst_n) begin
      state      <= IDLE;
      cnt        <= '0;
      sh         <= '0;
      rx         <= '0;
      hold       <= '0;
      hold_full  <= 1'b0;
      fresh      <= 1'b0;
      RXData     <= '0;
      RXAck      <= 1'b0;
      TXUnderrun <= 1'b0;
      Abort      <= 1'b0;
    end else begin
      state      <= state_nx;
      RXAck      <= wrap;
      TXUnderrun <= load && !hold_full;
      Abort      <= rise_p && state != IDLE && cnt != '0;
      hold_full  <= accept || (hold_full && !load);
      if (accept) hold <= TXData;
      if (samp) begin
        rx  <= rx_nx;
        cnt <= wrap ? '0 : cnt + 1'b1;
      end
      if (wrap) RXData <= rx_nx;
      // with CPHA=1 the first leading edge only exposes bit 0 already loaded at frame start
      if (rise_p) begin
        cnt   <= '0;
        sh    <= '0;
        fresh <= 1'b0;
      end else if (load) begin
        sh    <= hold_full ? hold : '0;
        fresh <= state == IDLE && CPHA != 0;
      end else if (shft && fresh) fresh <= 1'b0;
      else if (shft) sh <= MSB_FIRST != 0 ? sh << 1 : sh >> 1;
    end
  end
  assign MISO    = state != IDLE && (MSB_FIRST != 0 ? sh[DATA_WIDTH-1] : sh[0]);
  assign MISO_OE = state != IDLE;
  assign TXReady = !hold_full;
endmodule

// File: tb/tb_spi_slave_core.sv
// tb_spi_slave_core: four SPI slave configurations driven by a bit-level master model
module tb_spi_slave_core;
  localparam int SYNC = 2;
  int cw[4]     = '{8, 8, 16, 8};
  int cpol_a[4] = '{0, 1, 1, 0};
  int cpha_a[4] = '{0, 1, 0, 1};
  int msb_a[4]  = '{1, 0, 1, 1};
  logic clk = 1'b0;
  logic rst_n;
  logic [3:0] sck = 4'b0110, cs = 4'hF, mosi = 4'h0, txv = 4'h0;
  logic [3:0] miso, oe, txr, ack, und, abt;
  logic [15:0] txd [4];
  logic [15:0] rxd [4];
  logic [7:0] rx0, rx1, rx3;
  logic [15:0] rx2;
  int acks[4], unds[4], abts[4], ack_cyc[4], edge_cyc[4];
  int cyc = 0;
  logic [15:0] rxlog [4][$];
  logic [15:0] mw [3];
  logic [15:0] tw [3];
  logic [15:0] exp_rx [4];
  int n_chk = 0, n_fail = 0;
  always #5 clk = ~clk;
  always_comb begin
    rxd[0] = {8'h00, rx0};
    rxd[1] = {8'h00, rx1};
    rxd[2] = rx2;
    rxd[3] = {8'h00, rx3};
  end
  spi_slave_core #(.DATA_WIDTH(8), .CPOL(0), .CPHA(0), .MSB_FIRST(1), .SYNC_STAGES(SYNC)) u_m0 (
    .Clk(clk), .aRst_n(rst_n), .SCK(sck[0]), .CS(cs[0]), .MOSI(mosi[0]), .MISO(miso[0]), .MISO_OE(oe[0]),
    .TXData(txd[0][7:0]), .TXValid(txv[0]), .TXReady(txr[0]), .RXData(rx0), .RXAck(ack[0]),
    .TXUnderrun(und[0]), .Abort(abt[0]));
  spi_slave_core #(.DATA_WIDTH(8), .CPOL(1), .CPHA(1), .MSB_FIRST(0), .SYNC_STAGES(SYNC)) u_m3 (
    .Clk(clk), .aRst_n(rst_n), .SCK(sck[1]), .CS(cs[1]), .MOSI(mosi[1]), .MISO(miso[1]), .MISO_OE(oe[1]),
    .TXData(txd[1][7:0]), .TXValid(txv[1]), .TXReady(txr[1]), .RXData(rx1), .RXAck(ack[1]),
    .TXUnderrun(und[1]), .Abort(abt[1]));
  spi_slave_core #(.DATA_WIDTH(16), .CPOL(1), .CPHA(0), .MSB_FIRST(1), .SYNC_STAGES(SYNC)) u_m2 (
    .Clk(clk), .aRst_n(rst_n), .SCK(sck[2]), .CS(cs[2]), .MOSI(mosi[2]), .MISO(miso[2]), .MISO_OE(oe[2]),
    .TXData(txd[2]), .TXValid(txv[2]), .TXReady(txr[2]), .RXData(rx2), .RXAck(ack[2]),
    .TXUnderrun(und[2]), .Abort(abt[2]));
  spi_slave_core #(.DATA_WIDTH(8), .CPOL(0), .CPHA(1), .MSB_FIRST(1), .SYNC_STAGES(SYNC)) u_m1 (
    .Clk(clk), .aRst_n(rst_n), .SCK(sck[3]), .CS(cs[3]), .MOSI(mosi[3]), .MISO(miso[3]), .MISO_OE(oe[3]),
    .TXData(txd[3][7:0]), .TXValid(txv[3]), .TXReady(txr[3]), .RXData(rx3), .RXAck(ack[3]),
    .TXUnderrun(und[3]), .Abort(abt[3]));
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk)
    for (int d = 0; d < 4; d++) begin
      if (ack[d] === 1'b1) begin
        acks[d]++;
        ack_cyc[d] = cyc;
        rxlog[d].push_back(rxd[d]);
      end
      if (und[d] === 1'b1) unds[d]++;
      if (abt[d] === 1'b1) abts[d]++;
    end
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  function automatic logic [15:0] rnd(input int w);
    return 16'($urandom_range(0, (1 << w) - 1));
  endfunction
  task automatic feed(input int d, input int s);
    int k = 0;
    int g = 0;
    while ((k < s || txv[d]) && g < 2000) begin
      @(negedge clk);
      g++;
      if (txv[d]) txv[d] = 1'b0;
      else if (txr[d] && k < s) begin
        txd[d] = tw[k];
        k++;
        txv[d] = 1'b1;
      end
    end
    if (s > 0) chk("feed_done", k, s);
  endtask
  // word i on MISO is the i-th supplied TX word, or zero once supply runs out;
  // a word is fetched at frame start and at the first shift point after each completed word
  task automatic frame(input int d, input int nb, input int half, input int s);
    int w = cw[d];
    int full = nb / w;
    int setup = half < 4 ? 4 : half;
    logic cp = cpol_a[d] != 0;
    int a0 = acks[d];
    int u0 = unds[d];
    int b0 = abts[d];
    int r0 = rxlog[d].size();
    int loads = cpha_a[d] != 0 ? (nb + w - 1) / w : 1 + full;
    logic [15:0] mr [3];
    logic bit_v, got;
    for (int i = 0; i < 3; i++) mr[i] = '0;
    fork
      feed(d, s);
      begin
        repeat (6) @(negedge clk);
        cs[d] = 1'b0;
        repeat (setup) @(negedge clk);
        for (int b = 0; b < nb; b++) begin
          int wi = b / w;
          int bp = msb_a[d] != 0 ? w - 1 - b % w : b % w;
          bit_v = mw[wi][bp];
          if (cpha_a[d] == 0) begin
            mosi[d] = bit_v;
            repeat (half) @(negedge clk);
            got = miso[d];
            sck[d] = !cp;
            if (b == nb - 1) edge_cyc[d] = cyc;
            repeat (half) @(negedge clk);
            sck[d] = cp;
          end else begin
            sck[d] = !cp;
            mosi[d] = bit_v;
            repeat (half) @(negedge clk);
            got = miso[d];
            sck[d] = cp;
            if (b == nb - 1) edge_cyc[d] = cyc;
            repeat (half) @(negedge clk);
          end
          mr[wi][bp] = got;
          if (b == 0) chk("oe_active", oe[d], 1);
        end
        repeat (half) @(negedge clk);
        cs[d] = 1'b1;
        repeat (20) @(negedge clk);
      end
    join
    chk("rxack_count", acks[d] - a0, full);
    chk("underrun_count", unds[d] - u0, loads - s);
    chk("abort_count", abts[d] - b0, nb % w != 0);
    for (int i = 0; i < full; i++)
      if (r0 + i < rxlog[d].size()) chk("rx_word", rxlog[d][r0 + i], mw[i]);
    if (full > 0) exp_rx[d] = mw[full - 1];
    chk("rxdata_held", rxd[d], exp_rx[d]);
    if (half >= 5)
      for (int i = 0; i < full; i++) chk("miso_word", mr[i], i < s ? tw[i] : 16'h0);
    chk("oe_idle", oe[d], 0);
    chk("miso_idle", miso[d], 0);
  endtask
  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
  initial begin
    for (int d = 0; d < 4; d++) begin
      txd[d] = '0;
      exp_rx[d] = '0;
    end
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    for (int d = 0; d < 4; d++) begin
      chk("rst_txready", txr[d], 1);
      chk("rst_oe", oe[d], 0);
      chk("rst_miso", miso[d], 0);
      chk("rst_rxdata", rxd[d], 0);
      chk("rst_pulses", {ack[d], und[d], abt[d]}, 0);
    end
    mw[0] = 16'h3C; tw[0] = 16'hA5;
    frame(0, 8, 8, 1);
    mw[0] = 16'h81; mw[1] = 16'h7E; tw[0] = 16'h12; tw[1] = 16'h34;
    frame(1, 16, 8, 2);
    mw[0] = 16'hC7;
    frame(3, 8, 8, 0);
    mw[0] = 16'hFF;
    frame(0, 5, 8, 0);
    mw[0] = 16'hBEEF;
    frame(2, 16, 2, 0);
    chk("rxack_latency", ack_cyc[2] - edge_cyc[2], 1 + (SYNC + 1));
    for (int r = 0; r < 3; r++)
      for (int d = 0; d < 4; d++) begin
        int nw = $urandom_range(1, 3);
        int s = $urandom_range(0, nw);
        for (int i = 0; i < 3; i++) begin
          mw[i] = rnd(cw[d]);
          tw[i] = rnd(cw[d]);
        end
        frame(d, nw * cw[d], d == 2 ? $urandom_range(5, 7) : $urandom_range(5, 9), s);
      end
    for (int d = 0; d < 4; d++) begin
      mw[0] = rnd(cw[d]);
      frame(d, $urandom_range(1, cw[d] - 1), 6, 0);
    end
    cs[0] = 1'b0;
    repeat (8) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      mosi[0] = i[0];
      repeat (6) @(negedge clk);
      sck[0] = 1'b1;
      repeat (6) @(negedge clk);
      sck[0] = 1'b0;
    end
    tw[0] = 16'h99;
    feed(0, 1);
    chk("txready_full", txr[0], 0);
    #3 rst_n = 1'b0;
    #1;
    chk("arst_miso", miso[0], 0);
    chk("arst_oe", oe[0], 0);
    chk("arst_txready", txr[0], 1);
    chk("arst_rxdata", rxd[0], 0);
    chk("arst_pulses", {ack[0], und[0], abt[0]}, 0);
    cs[0] = 1'b1;
    mosi[0] = 1'b0;
    repeat (4) @(negedge clk);
    rst_n = 1'b1;
    for (int d = 0; d < 4; d++) exp_rx[d] = '0;
    repeat (4) @(negedge clk);
    mw[0] = 16'hC3; tw[0] = 16'h5A;
    frame(0, 8, 7, 1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
